// File: rtl/sum_display_ctrl_if.sv
// Adder-result capture and 7-segment display bus.
// The master drives the adder result and load strobe; the slave drives the display and result.
interface sum_display_ctrl_if;
  logic [3:0] sum_in;
  logic       cout_in;
  logic       load;
  logic [4:0] sum_q;
  logic       ovf_led;
  logic [6:0] seg;
  logic [3:0] an;

  modport master (
    output sum_in, cout_in, load,
    input  sum_q, ovf_led, seg, an
  );

  modport slave (
    input  sum_in, cout_in, load,
    output sum_q, ovf_led, seg, an
  );
endinterface

// File: rtl/sum_display_ctrl.sv
// Captures the adder result, converts it to BCD one cycle later and scans two digits.
// Each digit slot starts with a blanking period; seg/an latch only at the DEAD->ON edge.
module sum_display_ctrl #(
  parameter int SCAN_DIV      = 100000,
  parameter int DEAD_CYC      = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  sum_display_ctrl_if.slave  bus
);
  localparam int CW = $clog2(SCAN_DIV);

  typedef enum logic {ST_DEAD, ST_ON} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          idx_q;
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic [4:0]    res_q;
  logic [1:0]    tens_q;
  logic [3:0]    ones_q;

  logic [1:0]    tens_d;
  logic [4:0]    ones_full_d;
  logic [3:0]    ones_d;
  logic [3:0]    dig_d;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  function automatic logic [6:0] enc7(input logic [3:0] d);
    case (d)
      4'd0:    enc7 = 7'b1000000;
      4'd1:    enc7 = 7'b1111001;
      4'd2:    enc7 = 7'b0100100;
      4'd3:    enc7 = 7'b0110000;
      4'd4:    enc7 = 7'b0011001;
      4'd5:    enc7 = 7'b0010010;
      4'd6:    enc7 = 7'b0000010;
      4'd7:    enc7 = 7'b1111000;
      4'd8:    enc7 = 7'b0000000;
      4'd9:    enc7 = 7'b0010000;
      default: enc7 = 7'b1111111;
    endcase
  endfunction

  always_comb begin
    tens_d      = {1'b0, res_q >= 5'd10} + {1'b0, res_q >= 5'd20} + {1'b0, res_q >= 5'd30};
    ones_full_d = res_q - ({3'b000, tens_d} * 5'd10);
    ones_d      = ones_full_d[3:0];
    dig_d       = idx_q ? {2'b00, tens_q} : ones_q;
    seg_d       = enc7(dig_d);
    if (!idx_q)
      an_d = 4'b1110;
    else if (BLANK_LEADING && (tens_q == 2'd0))
      an_d = 4'b1111;
    else
      an_d = 4'b1101;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      if (bus.load)
        res_q <= {bus.cout_in, bus.sum_in};
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  // cnt runs through the whole slot; DEAD and ON only decide what is driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_DEAD;
      cnt_q   <= '0;
      idx_q   <= 1'b0;
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
    end else begin
      cnt_q <= (cnt_q == CW'(SCAN_DIV - 1)) ? '0 : cnt_q + 1'b1;
      case (state_q)
        ST_DEAD: begin
          if (cnt_q == CW'(DEAD_CYC - 1)) begin
            state_q <= ST_ON;
            seg_q   <= seg_d;
            an_q    <= an_d;
          end
        end
        ST_ON: begin
          if (cnt_q == CW'(SCAN_DIV - 1)) begin
            state_q <= ST_DEAD;
            idx_q   <= ~idx_q;
            seg_q   <= 7'b1111111;
            an_q    <= 4'b1111;
          end
        end
        default: state_q <= ST_DEAD;
      endcase
    end
  end

  assign bus.sum_q   = res_q;
  assign bus.ovf_led = res_q[4];
  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
endmodule
